// File: rtl/rls_iter_ctrl.sv
// rls_iter_ctrl -- micro-op sequencer for a 2-tap RLS adaptive filter.
//
// Each accepted sample (x, d) runs one RLS iteration on a shared pipelined
// multiplier and a shared divider. The phases run in a fixed order:
//   PV(0-3) KDEN(4-5) DIV(k0,k1) YOUT(6-7) WUPD(8-9) KX(10-13) PUPD(14-21) DONE
// Each multiplier phase issues its ops back to back and then waits MUL_LAT
// cycles so that its last result has landed before the next phase reads it.
//
// Optional feature macro: RLS_DIV_TIMEOUT_EN -- abort the iteration and set
// a sticky err flag when the divider does not answer within DIV_TO cycles.
//
// Ports:
//   clk, reset (async, active low)
//   sample_valid / sample_ready      sample handshake
//   flush                            synchronous abort to IDLE
//   mul_issue, mul_op[4:0]           multiplier issue and operand select
//   res_we, res_idx[4:0]             multiplier result write-back
//   div_start, div_sel, div_done     divider handshake
//   k_we                             latch divider result into k[div_sel]
//   commit, y_valid                  end-of-iteration pulses
//   busy, err, iter_cnt[CNT_W-1:0]   status
module rls_iter_ctrl #(
  parameter int MUL_LAT = 2,
  parameter int DIV_TO  = 32,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_valid,
  output logic             sample_ready,
  input  logic             flush,
  output logic             mul_issue,
  output logic [4:0]       mul_op,
  output logic             res_we,
  output logic [4:0]       res_idx,
  output logic             div_start,
  output logic             div_sel,
  input  logic             div_done,
  output logic             k_we,
  output logic             commit,
  output logic             y_valid,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] iter_cnt
);

  if (MUL_LAT < 1 || MUL_LAT > 7) begin : g_bad_lat
    $error("rls_iter_ctrl: MUL_LAT must be 1..7");
  end
  if (DIV_TO < 4 || DIV_TO > 255) begin : g_bad_to
    $error("rls_iter_ctrl: DIV_TO must be 4..255");
  end

  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_PV   = 4'd1;
  localparam logic [3:0] S_KDEN = 4'd2;
  localparam logic [3:0] S_DIV  = 4'd3;
  localparam logic [3:0] S_YOUT = 4'd4;
  localparam logic [3:0] S_WUPD = 4'd5;
  localparam logic [3:0] S_KX   = 4'd6;
  localparam logic [3:0] S_PUPD = 4'd7;
  localparam logic [3:0] S_DONE = 4'd8;

  localparam logic [4:0] LAT5 = 5'(MUL_LAT);

  logic [3:0] state;
  logic [3:0] ph_cnt;      // cycle within a multiplier phase
  logic       div_ph;      // 0: k0 division, 1: k1 division
  logic       div_wait;    // start issued, waiting for div_done
  logic       mul_phase;
  logic [4:0] op_base;
  logic [3:0] n_ops;
  logic [3:0] nxt_state;
  logic       phase_last;
  logic       to_hit;
  logic       pipe_clr;

  // Phase table: first op code, op count and successor of each mul phase.
  always_comb begin
    mul_phase = 1'b1;
    op_base   = 5'd0;
    n_ops     = 4'd0;
    nxt_state = S_IDLE;
    case (state)
      S_PV:    begin op_base = 5'd0;  n_ops = 4'd4; nxt_state = S_KDEN; end
      S_KDEN:  begin op_base = 5'd4;  n_ops = 4'd2; nxt_state = S_DIV;  end
      S_YOUT:  begin op_base = 5'd6;  n_ops = 4'd2; nxt_state = S_WUPD; end
      S_WUPD:  begin op_base = 5'd8;  n_ops = 4'd2; nxt_state = S_KX;   end
      S_KX:    begin op_base = 5'd10; n_ops = 4'd4; nxt_state = S_PUPD; end
      S_PUPD:  begin op_base = 5'd14; n_ops = 4'd8; nxt_state = S_DONE; end
      default: mul_phase = 1'b0;
    endcase
  end

  assign phase_last = mul_phase &&
                      ({1'b0, ph_cnt} == ({1'b0, n_ops} + LAT5 - 5'd1));

  // All strobes are masked by flush so an aborted cycle has no side effects.
  assign sample_ready = (state == S_IDLE) & ~flush;
  assign busy         = (state != S_IDLE);
  assign mul_issue    = mul_phase & (ph_cnt < n_ops) & ~flush;
  assign mul_op       = mul_issue ? (op_base + {1'b0, ph_cnt}) : 5'd0;
  assign div_start    = (state == S_DIV) & ~div_wait & ~flush;
  assign div_sel      = div_ph;
  assign k_we         = (state == S_DIV) & div_wait & div_done & ~flush;
  assign commit       = (state == S_DONE) & ~flush;
  assign y_valid      = commit;

`ifdef RLS_DIV_TIMEOUT_EN
  logic [7:0] to_cnt;   // cycles since the last div_start
  logic       err_q;

  assign to_hit   = (state == S_DIV) & div_wait & ~div_done &
                    (to_cnt == 8'(DIV_TO - 1));
  assign pipe_clr = flush | to_hit;
  assign err      = err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      to_cnt <= 8'd0;
      err_q  <= 1'b0;
    end else begin
      if (div_start)
        to_cnt <= 8'd1;
      else if ((state == S_DIV) && div_wait)
        to_cnt <= to_cnt + 8'd1;
      if (flush)
        err_q <= 1'b0;
      else if (to_hit)
        err_q <= 1'b1;
    end
  end
`else
  assign to_hit   = 1'b0;
  assign pipe_clr = flush;
  assign err      = 1'b0;
`endif

  // Sequencer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      ph_cnt   <= 4'd0;
      div_ph   <= 1'b0;
      div_wait <= 1'b0;
      iter_cnt <= '0;
    end else if (flush) begin
      state    <= S_IDLE;
      ph_cnt   <= 4'd0;
      div_ph   <= 1'b0;
      div_wait <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (sample_valid) begin
            state  <= S_PV;
            ph_cnt <= 4'd0;
          end
        end
        S_DIV: begin
          if (!div_wait) begin
            div_wait <= 1'b1;
          end else if (div_done) begin
            div_wait <= 1'b0;
            if (div_ph) begin
              div_ph <= 1'b0;
              state  <= S_YOUT;
            end else begin
              div_ph <= 1'b1;
            end
          end else if (to_hit) begin
            div_wait <= 1'b0;
            div_ph   <= 1'b0;
            state    <= S_IDLE;
          end
        end
        S_DONE: begin
          state    <= S_IDLE;
          iter_cnt <= iter_cnt + 1'b1;
        end
        default: begin
          if (phase_last) begin
            ph_cnt <= 4'd0;
            state  <= nxt_state;
          end else begin
            ph_cnt <= ph_cnt + 4'd1;
          end
        end
      endcase
    end
  end

  // Result pipeline: issue strobe and op code delayed by MUL_LAT cycles.
  logic [MUL_LAT-1:0]      vld_pipe;
  logic [MUL_LAT-1:0][4:0] idx_pipe;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_pipe <= '0;
      idx_pipe <= '0;
    end else if (pipe_clr) begin
      vld_pipe <= '0;
      idx_pipe <= '0;
    end else begin
      vld_pipe[0] <= mul_issue;
      idx_pipe[0] <= mul_op;
      for (int i = 1; i < MUL_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        idx_pipe[i] <= idx_pipe[i-1];
      end
    end
  end

  assign res_we  = vld_pipe[MUL_LAT-1] & ~flush;
  assign res_idx = idx_pipe[MUL_LAT-1];

endmodule

// File: tb/tb_rls_iter_ctrl.sv
// Self-checking bench for rls_iter_ctrl. A schedule model derives, from the
// phase list and op counts alone, which strobes must fire at each cycle
// offset from sample acceptance; the DUT is compared against it every cycle.
module tb_rls_iter_ctrl;
  localparam int ML  = 2;
  localparam int TO  = 32;
  localparam int CW  = 16;
  localparam int WIN = 200;
  localparam int NEVER = 1000;

  logic          clk = 1'b0;
  logic          reset;
  logic          sample_valid, sample_ready, flush;
  logic          mul_issue, res_we, div_start, div_sel, div_done;
  logic [4:0]    mul_op, res_idx;
  logic          k_we, commit, y_valid, busy, err;
  logic [CW-1:0] iter_cnt;

  int errs   = 0;
  int checks = 0;
  int exp_iter = 0;

  // expected schedule, indexed by cycle offset from the accept cycle
  bit e_iss [WIN];
  int e_op  [WIN];
  bit e_we  [WIN];
  int e_idx [WIN];
  bit e_ds  [WIN];
  bit e_dsel[WIN];
  bit e_kwe [WIN];
  bit e_cm  [WIN];

  rls_iter_ctrl #(.MUL_LAT(ML), .DIV_TO(TO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .flush(flush), .mul_issue(mul_issue),
    .mul_op(mul_op), .res_we(res_we), .res_idx(res_idx),
    .div_start(div_start), .div_sel(div_sel), .div_done(div_done),
    .k_we(k_we), .commit(commit), .y_valid(y_valid), .busy(busy),
    .err(err), .iter_cnt(iter_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // A multiplier phase: n ops on consecutive cycles, results MUL_LAT later,
  // then the phase lasts MUL_LAT more cycles before the next one begins.
  task automatic mk_phase(inout int t, input int base, input int n);
    for (int i = 0; i < n; i++) begin
      if (t + i < WIN)      begin e_iss[t+i] = 1; e_op[t+i] = base + i; end
      if (t + i + ML < WIN) begin e_we[t+i+ML] = 1; e_idx[t+i+ML] = base + i; end
    end
    t = t + n + ML;
  endtask

  task automatic build(input int d0, input int d1, output int done_off,
                       output int ds0, output int ds1);
    int t;
    for (int i = 0; i < WIN; i++) begin
      e_iss[i] = 0; e_op[i] = 0; e_we[i] = 0; e_idx[i] = 0;
      e_ds[i] = 0; e_dsel[i] = 0; e_kwe[i] = 0; e_cm[i] = 0;
    end
    t = 1;
    mk_phase(t, 0, 4);
    mk_phase(t, 4, 2);
    ds0 = t;
    if (t < WIN) e_ds[t] = 1;
    if (t + d0 < WIN) e_kwe[t+d0] = 1;
    t = t + d0 + 1;
    ds1 = t;
    if (t < WIN) begin e_ds[t] = 1; e_dsel[t] = 1; end
    if (t + d1 < WIN) e_kwe[t+d1] = 1;
    t = t + d1 + 1;
    mk_phase(t, 6, 2);
    mk_phase(t, 8, 2);
    mk_phase(t, 10, 4);
    mk_phase(t, 14, 8);
    done_off = t;
    if (t < WIN) e_cm[t] = 1;
  endtask

  // One cycle with all inputs low.
  task automatic idle_cycle();
    @(posedge clk); #1;
    sample_valid = 0; flush = 0; div_done = 0;
    @(negedge clk);
  endtask

  // Runs one iteration from its accept cycle, checking every cycle against
  // the schedule. flush_off/stop_off (>= 0) end the run early.
  task automatic run_iter(input int d0, input int d1, input int flush_off,
                          input int stop_off, input bit hold, input bit spur);
    int done_off, ds0, ds1, last;
    logic [19:0] obs, ex;
    build(d0, d1, done_off, ds0, ds1);
    last = (done_off < WIN - 1) ? done_off : WIN - 1;
    for (int off = 0; off <= last; off++) begin
      @(posedge clk); #1;
      sample_valid = hold || (off == 0);
      flush        = (off == flush_off);
      div_done     = (off == ds0 + d0) || (off == ds1 + d1) ||
                     (spur && (off == 2 || off == done_off - 1));
      @(negedge clk);
      if (off == flush_off) break;
      if (off == 0) begin
        checks++;
        if (iter_cnt !== CW'(exp_iter)) begin
          errs++;
          $display("FAIL iter_cnt at accept: got %0d expected %0d", iter_cnt, exp_iter);
        end
      end
      obs = {mul_issue, mul_issue ? mul_op : 5'd0, res_we, res_we ? res_idx : 5'd0,
             div_start, div_start ? div_sel : 1'b0, k_we, commit, y_valid,
             busy, sample_ready, err};
      ex  = {e_iss[off], 5'(e_op[off]), e_we[off], 5'(e_idx[off]),
             e_ds[off], e_dsel[off], e_kwe[off], e_cm[off], e_cm[off],
             off != 0, off == 0, 1'b0};
      checks++;
      if (obs !== ex) begin
        errs++;
        $display("FAIL sched off=%0d: got iss/op/we/idx/ds/sel/kwe/cm/yv/busy/rdy/err=%b expected %b",
                 off, obs, ex);
      end
      if (off == stop_off) break;
      if (off == done_off) exp_iter++;
    end
  endtask

  task automatic test_reset();
    reset = 0; sample_valid = 0; flush = 0; div_done = 0;
    repeat (5) @(posedge clk);
    #1 reset = 1;
    @(negedge clk);
    checks++;
    if ({mul_issue, res_we, div_start, k_we, commit, y_valid, busy, err} !== 8'b0 ||
        sample_ready !== 1'b1 || iter_cnt !== '0) begin
      errs++;
      $display("FAIL reset: strobes=%b rdy=%b iter=%0d expected strobes=0 rdy=1 iter=0",
               {mul_issue, res_we, div_start, k_we, commit, y_valid, busy, err},
               sample_ready, iter_cnt);
    end
    exp_iter = 0;
  endtask

  task automatic test_single();
    run_iter(3, 3, -1, -1, 0, 0);
    idle_cycle();
    checks++;
    if (iter_cnt !== CW'(1) || sample_ready !== 1'b1) begin
      errs++;
      $display("FAIL single end: iter=%0d rdy=%b expected iter=1 rdy=1", iter_cnt, sample_ready);
    end
  endtask

  task automatic test_back_to_back();
    run_iter(3, 3, -1, -1, 1, 0);
    run_iter(3, 3, -1, -1, 1, 0);
    run_iter(2, 4, -1, -1, 0, 0);
    idle_cycle();
    checks++;
    if (iter_cnt !== CW'(exp_iter)) begin
      errs++;
      $display("FAIL b2b count: got %0d expected %0d", iter_cnt, exp_iter);
    end
  endtask

  task automatic test_flush();
    run_iter(3, 3, 35, -1, 0, 0);
    for (int k = 0; k < 4; k++) begin
      idle_cycle();
      checks++;
      if ({res_we, commit, y_valid, busy, k_we} !== 5'b0 || sample_ready !== 1'b1 ||
          iter_cnt !== CW'(exp_iter)) begin
        errs++;
        $display("FAIL flush after+%0d: we/cm/yv/busy/kwe=%b rdy=%b iter=%0d expected 0 1 %0d",
                 k + 1, {res_we, commit, y_valid, busy, k_we}, sample_ready, iter_cnt, exp_iter);
      end
    end
    // flush beats a simultaneous sample_valid in IDLE
    @(posedge clk); #1;
    sample_valid = 1; flush = 1;
    @(negedge clk);
    idle_cycle();
    checks++;
    if (busy !== 1'b0) begin
      errs++;
      $display("FAIL flush vs accept: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_async_reset();
    run_iter(NEVER, 3, -1, 13, 0, 0);
    #2 reset = 0;
    #1;
    checks++;
    if ({mul_issue, res_we, div_start, k_we, commit, busy, err} !== 7'b0 ||
        iter_cnt !== '0) begin
      errs++;
      $display("FAIL async reset: strobes=%b iter=%0d expected 0 0",
               {mul_issue, res_we, div_start, k_we, commit, busy, err}, iter_cnt);
    end
    exp_iter = 0;
    @(posedge clk); #1 reset = 1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      sample_valid = 0; flush = 0; div_done = (k == 1);
      @(negedge clk);
      checks++;
      if (k_we !== 1'b0 || busy !== 1'b0) begin
        errs++;
        $display("FAIL stale div_done k=%0d: k_we=%b busy=%b expected 0 0", k, k_we, busy);
      end
    end
  endtask

  task automatic test_div_stall();
    bit exp_err, exp_busy;
    run_iter(NEVER, NEVER, -1, 11, 0, 0);
    for (int k = 12; k < 11 + TO + 6; k++) begin
      idle_cycle();
`ifdef RLS_DIV_TIMEOUT_EN
      exp_err  = (k >= 11 + TO);
      exp_busy = (k <  11 + TO);
`else
      exp_err  = 0;
      exp_busy = 1;
`endif
      checks++;
      if (err !== exp_err || busy !== exp_busy || commit !== 1'b0 || div_start !== 1'b0) begin
        errs++;
        $display("FAIL div stall off=%0d: err=%b busy=%b cm=%b ds=%b expected %b %b 0 0",
                 k, err, busy, commit, div_start, exp_err, exp_busy);
      end
    end
    @(posedge clk); #1 flush = 1;
    @(negedge clk);
    idle_cycle();
    checks++;
    if (err !== 1'b0 || busy !== 1'b0 || iter_cnt !== CW'(exp_iter)) begin
      errs++;
      $display("FAIL stall recovery: err=%b busy=%b iter=%0d expected 0 0 %0d",
               err, busy, iter_cnt, exp_iter);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++) begin
      run_iter(int'($urandom_range(1, 6)), int'($urandom_range(1, 6)), -1, -1,
               bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) idle_cycle();
    end
    idle_cycle();
    checks++;
    if (iter_cnt !== CW'(exp_iter)) begin
      errs++;
      $display("FAIL random count: got %0d expected %0d", iter_cnt, exp_iter);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_flush();
    test_div_stall();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/rls_iter_ctrl.md
Name: rls_iter_ctrl

Overview:
Sequencer for a 2-tap RLS adaptive filter datapath built around one shared pipelined 16x16 multiplier and one shared divider. Each accepted input sample (x, d) runs one full RLS iteration as 22 multiplier micro-ops and 2 divisions, in a fixed order. The block drives operand-select codes, result write strobes and the w/P commit pulse. It sits between the sample source and the time-multiplexed RLS datapath.

Parameters:
MUL_LAT, 2, multiplier pipeline latency in cycles (1..7); result for an op issued at cycle t is valid at t+MUL_LAT
DIV_TO, 32, divider timeout in cycles (only with RLS_DIV_TIMEOUT_EN); 4..255
CNT_W, 16, width of iteration counter

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  asynchronous active-low reset
sample_valid  in  1  new (x_in, d_in) presented
sample_ready  out  1  controller can accept a sample
flush  in  1  synchronous abort to IDLE
mul_issue  out  1  micro-op issued to the multiplier this cycle
mul_op  out  5  op code of the issued micro-op (operand mux select)
res_we  out  1  multiplier result write strobe
res_idx  out  5  op code the current result belongs to
div_start  out  1  one-cycle divider start pulse
div_sel  out  1  0: k_0 division, 1: k_1 division
div_done  in  1  divider result valid (one-cycle pulse)
k_we  out  1  latch divider result into k[div_sel]
commit  out  1  one-cycle pulse: load updated w1/w2 and P into state registers
y_valid  out  1  one-cycle pulse: y_out is valid
busy  out  1  iteration in progress
err  out  1  sticky divider timeout flag (0 when feature compiled out)
iter_cnt  out  CNT_W  completed iterations, wraps to 0

Behaviour:
- Reset (async, reset=0): state IDLE; all strobes 0; sample_ready=1 once released; busy=0; err=0; iter_cnt=0; result pipeline cleared.
- sample_ready=1 only in IDLE and flush=0. Accept = sample_valid & sample_ready; next cycle starts phase PV. busy=1 from the cycle after accept through DONE.
- States: IDLE, PV, KDEN, DIV, YOUT, WUPD, KX, PUPD, DONE.
- Multiplier phases and op codes: PV ops 0-3 (x*P terms), KDEN ops 4-5 (v*x), YOUT ops 6-7 (x*w), WUPD ops 8-9 (k*e), KX ops 10-13 (x*k), PUPD ops 14-21 (kx*P).
- In each multiplier phase, ops issue on consecutive cycles in ascending order (mul_issue=1). The phase then waits MUL_LAT drain cycles. Phase length = N_ops + MUL_LAT, after which the FSM moves to the next state.
- res_we/res_idx are mul_issue/mul_op delayed exactly MUL_LAT cycles through an internal shift pipeline. The pipeline is cleared on reset and on flush.
- DIV phase:
  - div_start=1 with div_sel=0 on entry cycle, then wait for div_done; k_we=1 in the div_done cycle.
  - Next cycle: div_start with div_sel=1, wait, k_we on done; next cycle go to YOUT.
  - div_done outside a wait window is ignored.
- DONE lasts one cycle: commit=1, y_valid=1, iter_cnt+=1 (wraps at 2^CNT_W-1 -> 0); next state IDLE.
- Latency with divider done d cycles after start: DONE at accept + 1 + 22 + 6*MUL_LAT + 2*(d+1). With MUL_LAT=2, d=3: DONE at accept+43; sample_ready high again at accept+44.
- flush=1: next state IDLE from any state. No commit/y_valid/k_we; pending res_we suppressed; err cleared; iter_cnt kept. Flush wins over a simultaneous sample_valid in IDLE.
- Reset mid-iteration: immediate return to reset values; partial results not committed.
- Never more than one op issued per cycle; mul_issue and div_start never both 1.

Optional Feature:
RLS_DIV_TIMEOUT_EN:
- Defined: 8-bit counter starts at div_start. If DIV_TO cycles elapse without div_done, err is set (sticky), the FSM goes to IDLE without commit, and the pipeline is cleared.
- Undefined: DIV waits indefinitely; err tied 0; no counter logic.

Test Plan:
- Reset held low 5 cycles then released -> all strobes 0, sample_ready=1, iter_cnt=0, err=0.
- MUL_LAT=2, divider done 3 cycles after start, one sample accepted at T0 -> mul_op 0..3 on T0+1..T0+4; res_we idx 0 at T0+3; div_start at T0+11 and T0+15; commit and y_valid at T0+43 only; sample_ready back at T0+44; iter_cnt=1.
- Back-to-back samples with sample_valid held high -> second accept at T0+44; 22 res_we pulses per iteration with res_idx 0..21 in order; iter_cnt=2.
- flush asserted during PUPD (T0+35) -> IDLE at T0+36; no commit; no res_we after T0+35; iter_cnt unchanged.
- Async reset asserted during DIV wait -> outputs at reset values immediately; a later div_done produces no k_we.
- With RLS_DIV_TIMEOUT_EN, DIV_TO=32, div_done never returned -> err=1 at div_start+32, back to IDLE, no commit; flush clears err. Without the macro, controller stays in DIV, busy=1, err=0.
